// File: rtl/imem_access_ctrl.sv
// Arbitrates the single port of the 8-bit instruction SRAM between the program
// loader (byte writes) and CPU fetch (two byte reads, high byte first).
module imem_access_ctrl #(
    parameter int ADDR_W      = 9,
    parameter int LD_PRIORITY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_mode,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              ld_ack,
    input  logic              if_req,
    input  logic [ADDR_W-2:0] if_pc,
    output logic              if_valid,
    output logic [15:0]       if_instr,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_din,
    input  logic [7:0]        mem_dout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_HI,
        S_RD_LO,
        S_RD_WAIT
    } state_t;

    localparam logic LD_WINS = (LD_PRIORITY != 0);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [7:0]        mem_din_q, mem_din_d;
    logic              ld_ack_q, ld_ack_d;
    logic              if_valid_q, if_valid_d;
    logic [15:0]       if_instr_q, if_instr_d;
    logic [7:0]        hi_q, hi_d;

    logic fetch_ok;
    logic take_wr;
    logic take_rd;

    // Fetch is only eligible outside load mode; the tie goes to LD_PRIORITY.
    assign fetch_ok = if_req & ~ld_mode;
    assign take_wr  = ld_req & (~fetch_ok | LD_WINS);
    assign take_rd  = fetch_ok & (~ld_req | ~LD_WINS);

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        mem_we_d   = 1'b0;
        mem_din_d  = mem_din_q;
        ld_ack_d   = 1'b0;
        if_valid_d = 1'b0;
        if_instr_d = if_instr_q;
        hi_d       = hi_q;

        case (state_q)
            S_IDLE: begin
                if (take_wr) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = ld_addr;
                    mem_din_d  = ld_data;
                    ld_ack_d   = 1'b1;
                    state_d    = S_WR;
                end else if (take_rd) begin
                    mem_addr_d = {if_pc, 1'b0};
                    state_d    = S_RD_HI;
                end
            end
            S_WR: begin
                state_d = S_IDLE;
            end
            S_RD_HI: begin
                // Low byte address is formed by setting bit 0, so pc=max never carries.
                mem_addr_d = {mem_addr_q[ADDR_W-1:1], 1'b1};
                state_d    = S_RD_LO;
            end
            S_RD_LO: begin
                hi_d    = mem_dout;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if_instr_d = {hi_q, mem_dout};
                if_valid_d = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mem_addr_q <= '0;
            mem_we_q   <= 1'b0;
            mem_din_q  <= 8'h00;
            ld_ack_q   <= 1'b0;
            if_valid_q <= 1'b0;
            if_instr_q <= 16'h0000;
            hi_q       <= 8'h00;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            mem_we_q   <= mem_we_d;
            mem_din_q  <= mem_din_d;
            ld_ack_q   <= ld_ack_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            hi_q       <= hi_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign mem_addr = mem_addr_q;
    assign mem_we   = mem_we_q;
    assign mem_din  = mem_din_q;
    assign ld_ack   = ld_ack_q;
    assign if_valid = if_valid_q;
    assign if_instr = if_instr_q;

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Bench for imem_access_ctrl: SRAM stand-ins, a byte-array reference of memory
// contents, directed scenarios and a randomized write/fetch mix.
module tb_imem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_clr;

    // Instance with loader priority
    logic        ld_mode, ld_req, ld_ack, if_req, if_valid, busy, mem_we;
    logic [8:0]  ld_addr, mem_addr;
    logic [7:0]  ld_data, mem_din, mem_dout;
    logic [7:0]  if_pc;
    logic [15:0] if_instr;
    logic [7:0]  sram [512];

    // Instance with fetch priority
    logic        ld_mode0, ld_req0, ld_ack0, if_req0, if_valid0, busy0, mem_we0;
    logic [8:0]  ld_addr0, mem_addr0;
    logic [7:0]  ld_data0, mem_din0, mem_dout0;
    logic [7:0]  if_pc0;
    logic [15:0] if_instr0;
    logic [7:0]  sram0 [512];

    logic [7:0]  ref_mem [512];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    imem_access_ctrl #(.ADDR_W(9), .LD_PRIORITY(1)) u_dut (
        .clk(clk), .rst(rst), .ld_mode(ld_mode), .ld_req(ld_req),
        .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
        .if_req(if_req), .if_pc(if_pc), .if_valid(if_valid),
        .if_instr(if_instr), .busy(busy), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    imem_access_ctrl #(.ADDR_W(9), .LD_PRIORITY(0)) u_dut0 (
        .clk(clk), .rst(rst), .ld_mode(ld_mode0), .ld_req(ld_req0),
        .ld_addr(ld_addr0), .ld_data(ld_data0), .ld_ack(ld_ack0),
        .if_req(if_req0), .if_pc(if_pc0), .if_valid(if_valid0),
        .if_instr(if_instr0), .busy(busy0), .mem_addr(mem_addr0),
        .mem_we(mem_we0), .mem_din(mem_din0), .mem_dout(mem_dout0)
    );

    // SRAM devices: synchronous write, registered read held while writing
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 512; i++) sram[i] <= 8'h00;
            mem_dout <= 8'h00;
        end else if (mem_we) sram[mem_addr] <= mem_din;
        else mem_dout <= sram[mem_addr];
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 512; i++) sram0[i] <= 8'h00;
            mem_dout0 <= 8'h00;
        end else if (mem_we0) sram0[mem_addr0] <= mem_din0;
        else mem_dout0 <= sram0[mem_addr0];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ref_word(input logic [7:0] pc);
        return {ref_mem[{pc, 1'b0}], ref_mem[{pc, 1'b1}]};
    endfunction

    task automatic do_write(input logic [8:0] addr, input logic [7:0] data);
        int   n;
        logic done;
        n = 0; done = 1'b0;
        ld_addr = addr; ld_data = data; ld_req = 1'b1;
        while (!done && n < 20) begin
            step(); n++;
            if (ld_ack) done = 1'b1;
        end
        check("wr_done", 32'(done), 32'd1);
        check("wr_latency", 32'(n), 32'd1);
        check("wr_we", 32'(mem_we), 32'd1);
        check("wr_addr", 32'(mem_addr), 32'(addr));
        check("wr_din", 32'(mem_din), 32'(data));
        ld_req = 1'b0;
        step();
        check("wr_ack_pulse", 32'(ld_ack), 32'd0);
        check("wr_we_drop", 32'(mem_we), 32'd0);
        check("wr_din_hold", 32'(mem_din), 32'(data));
        ref_mem[addr] = data;
        $display("txn write addr=%0d data=%02h cycles=%0d", addr, data, n);
    endtask

    task automatic do_fetch(input logic [7:0] pc, input logic move_pc);
        int          n;
        logic        done;
        logic [15:0] exp;
        n = 0; done = 1'b0;
        exp = ref_word(pc);
        if_pc = pc; if_req = 1'b1;
        while (!done && n < 20) begin
            step(); n++;
            if (if_valid) done = 1'b1;
            else begin
                check("rd_busy", 32'(busy), 32'd1);
                check("rd_we", 32'(mem_we), 32'd0);
            end
            if (move_pc && n == 1) if_pc = 8'($urandom);
        end
        check("rd_done", 32'(done), 32'd1);
        check("rd_latency", 32'(n), 32'd4);
        check("rd_instr", 32'(if_instr), 32'(exp));
        check("rd_idle", 32'(busy), 32'd0);
        if_req = 1'b0;
        step();
        check("rd_valid_pulse", 32'(if_valid), 32'd0);
        check("rd_instr_hold", 32'(if_instr), 32'(exp));
        $display("txn fetch pc=%0d instr=%04h exp=%04h cycles=%0d", pc, if_instr, exp, n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          n, n_ld, n_if, cnt_v, cnt_b;
        logic [15:0] got_instr, exp_instr;
        logic [8:0]  a;
        logic [7:0]  d, p;

        for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;
        rst = 1'b1; mem_clr = 1'b1;
        ld_mode = 0; ld_req = 0; if_req = 0; ld_addr = 0; ld_data = 0; if_pc = 0;
        ld_mode0 = 0; ld_req0 = 0; if_req0 = 0; ld_addr0 = 0; ld_data0 = 0; if_pc0 = 0;

        // Reset state
        step(); step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack", 32'(ld_ack), 32'd0);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_instr", 32'(if_instr), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_din", 32'(mem_din), 32'd0);
        rst = 1'b0; mem_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_we", 32'(mem_we), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end

        // Load then fetch
        do_write(9'd6, 8'hA5);
        do_write(9'd7, 8'h3C);
        do_fetch(8'd3, 1'b0);
        check("fetch_a53c", 32'(if_instr), 32'h0000A53C);

        // Top-of-memory word, with if_pc disturbed after acceptance
        do_write(9'd510, 8'hFF);
        do_write(9'd511, 8'h01);
        do_fetch(8'd255, 1'b1);
        check("fetch_ff01", 32'(if_instr), 32'h0000FF01);

        // Simultaneous requests, loader wins: write lands before the fetch reads it
        ld_addr = 9'd8; ld_data = 8'h11; if_pc = 8'd4;
        ld_req = 1'b1; if_req = 1'b1;
        n = 0; n_ld = 0; n_if = 0; got_instr = 16'h0;
        while ((n_ld == 0 || n_if == 0) && n < 30) begin
            step(); n++;
            if (ld_ack && n_ld == 0) begin n_ld = n; ld_req = 1'b0; end
            if (if_valid && n_if == 0) begin n_if = n; if_req = 1'b0; got_instr = if_instr; end
        end
        ref_mem[8] = 8'h11;
        check("both_ld_cycle", 32'(n_ld), 32'd1);
        check("both_if_cycle", 32'(n_if), 32'd6);
        check("both_instr", 32'(got_instr), 32'(ref_word(8'd4)));
        $display("txn both(ld prio) ack@%0d valid@%0d instr=%04h", n_ld, n_if, got_instr);
        step();

        // ld_mode blocks fetch; dropping it lets the fetch in on the next edge
        ld_mode = 1'b1; if_pc = 8'd3; if_req = 1'b1;
        cnt_v = 0; cnt_b = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (if_valid) cnt_v++;
            if (busy) cnt_b++;
        end
        check("ldmode_valid", 32'(cnt_v), 32'd0);
        check("ldmode_busy", 32'(cnt_b), 32'd0);
        ld_mode = 1'b0;
        n = 0;
        while (!if_valid && n < 20) begin step(); n++; end
        check("ldmode_release_lat", 32'(n), 32'd4);
        check("ldmode_release_instr", 32'(if_instr), 32'(ref_word(8'd3)));
        if_req = 1'b0;
        step();
        $display("txn fetch after ld_mode drop cycles=%0d instr=%04h", n, if_instr);

        // Reset while in RD_LO discards the fetch
        rst = 1'b1; step(); rst = 1'b0;
        check("rst2_instr", 32'(if_instr), 32'd0);
        if_pc = 8'd5; if_req = 1'b1;
        step(); step();
        check("rst2_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1; if_req = 1'b0;
        step();
        check("rst2_busy", 32'(busy), 32'd0);
        check("rst2_we", 32'(mem_we), 32'd0);
        check("rst2_valid", 32'(if_valid), 32'd0);
        rst = 1'b0;
        cnt_v = 0;
        for (int i = 0; i < 6; i++) begin step(); if (if_valid) cnt_v++; end
        check("rst2_no_valid", 32'(cnt_v), 32'd0);
        check("rst2_instr_zero", 32'(if_instr), 32'd0);
        $display("txn reset mid-fetch valid_count=%0d", cnt_v);
        do_fetch(8'd5, 1'b0);

        // Simultaneous requests, fetch wins: fetch sees old byte, write follows
        ld_addr0 = 9'd1; ld_data0 = 8'h5A; if_pc0 = 8'd0;
        ld_req0 = 1'b1; if_req0 = 1'b1;
        n = 0; n_ld = 0; n_if = 0; got_instr = 16'hFFFF;
        while ((n_ld == 0 || n_if == 0) && n < 30) begin
            step(); n++;
            if (ld_ack0 && n_ld == 0) begin n_ld = n; ld_req0 = 1'b0; end
            if (if_valid0 && n_if == 0) begin n_if = n; if_req0 = 1'b0; got_instr = if_instr0; end
        end
        check("fprio_if_cycle", 32'(n_if), 32'd4);
        check("fprio_ld_cycle", 32'(n_ld), 32'd5);
        check("fprio_instr", 32'(got_instr), 32'h00000000);
        $display("txn both(fetch prio) valid@%0d ack@%0d instr=%04h", n_if, n_ld, got_instr);
        step();
        if_req0 = 1'b1;
        n = 0;
        while (!if_valid0 && n < 20) begin step(); n++; end
        exp_instr = 16'h005A;
        check("fprio_refetch", 32'(if_instr0), 32'(exp_instr));
        if_req0 = 1'b0;
        step();
        $display("txn fetch(fetch prio) pc=0 instr=%04h", if_instr0);

        // Randomized mix, concentrated on a small window so reads hit writes
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                a = ($urandom_range(0, 1) == 1) ? 9'($urandom_range(0, 15)) : 9'($urandom_range(0, 511));
                d = 8'($urandom);
                do_write(a, d);
            end else begin
                p = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
                do_fetch(p, ($urandom_range(0, 3) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
